// File: rtl/pointwise_psum_accum.sv
// pointwise_psum_accum
// Sums a configurable number of signed partial sums from the pointwise
// systolic column adder and hands the finished output-pixel sum to the
// output buffer over a valid/ready handshake. One instance per column.
//
// Optional build macro PSUM_ACCUM_SATURATE_EN: every add clamps to the signed
// OUT_BITWIDTH range and a sat_flag output reports whether the presented sum
// clamped. Without it the sum wraps in two's complement and sat_flag is absent.
module pointwise_psum_accum #(
    parameter int IN_BITWIDTH  = 32,
    parameter int OUT_BITWIDTH = 32,
    parameter int CNT_BITWIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CNT_BITWIDTH-1:0] cfg_num_beats,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_BITWIDTH-1:0]  in_psum,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_BITWIDTH-1:0] out_data,
`ifdef PSUM_ACCUM_SATURATE_EN
    output logic                    sat_flag,
`endif
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [OUT_BITWIDTH-1:0] acc_q, acc_d;
    logic [OUT_BITWIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_BITWIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_BITWIDTH-1:0] num_lat_q, num_lat_d;
`ifdef PSUM_ACCUM_SATURATE_EN
    logic                    sat_q, sat_d;
    logic [OUT_BITWIDTH:0]   sum_wide;
    logic                    add_ovf;
`endif

    logic [OUT_BITWIDTH-1:0] psum_ext;
    logic [OUT_BITWIDTH-1:0] sum_res;
    logic [CNT_BITWIDTH-1:0] cfg_eff;
    logic [CNT_BITWIDTH-1:0] cnt_inc;
    logic                    accept;

    // Sign-extend the incoming partial sum and form the (wrapping or clamping) running sum
    always_comb begin
        psum_ext = OUT_BITWIDTH'($signed(in_psum));
`ifdef PSUM_ACCUM_SATURATE_EN
        sum_wide = {acc_q[OUT_BITWIDTH-1], acc_q} + {psum_ext[OUT_BITWIDTH-1], psum_ext};
        add_ovf  = sum_wide[OUT_BITWIDTH] != sum_wide[OUT_BITWIDTH-1];
        if (!add_ovf) begin
            sum_res = sum_wide[OUT_BITWIDTH-1:0];
        end else if (sum_wide[OUT_BITWIDTH]) begin
            sum_res = {1'b1, {(OUT_BITWIDTH-1){1'b0}}};
        end else begin
            sum_res = {1'b0, {(OUT_BITWIDTH-1){1'b1}}};
        end
`else
        sum_res = acc_q + psum_ext;
`endif
    end

    // Handshake and count helpers; a zero beat count means a single-beat group
    always_comb begin
        in_ready = (state_q != HOLD);
        accept   = in_valid && in_ready;
        cfg_eff  = (cfg_num_beats == '0) ? CNT_BITWIDTH'(1) : cfg_num_beats;
        cnt_inc  = cnt_q + CNT_BITWIDTH'(1);
    end

    // Next-state logic: accumulate a group, then hold the result until it is taken
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        cnt_d      = cnt_q;
        num_lat_d  = num_lat_q;
`ifdef PSUM_ACCUM_SATURATE_EN
        sat_d      = sat_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    num_lat_d = cfg_eff;
                    acc_d     = psum_ext;
                    cnt_d     = CNT_BITWIDTH'(1);
`ifdef PSUM_ACCUM_SATURATE_EN
                    sat_d     = 1'b0;
`endif
                    if (cfg_eff == CNT_BITWIDTH'(1)) begin
                        out_data_d = psum_ext;
                        state_d    = HOLD;
                    end else begin
                        state_d    = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = sum_res;
                    cnt_d = cnt_inc;
`ifdef PSUM_ACCUM_SATURATE_EN
                    sat_d = sat_q | add_ovf;
`endif
                    if (cnt_inc == num_lat_q) begin
                        out_data_d = sum_res;
                        cnt_d      = '0;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    state_d = IDLE;
`ifdef PSUM_ACCUM_SATURATE_EN
                    sat_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial or held sum
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            out_data_q <= '0;
            cnt_q      <= '0;
            num_lat_q  <= '0;
`ifdef PSUM_ACCUM_SATURATE_EN
            sat_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            cnt_q      <= cnt_d;
            num_lat_q  <= num_lat_d;
`ifdef PSUM_ACCUM_SATURATE_EN
            sat_q      <= sat_d;
`endif
        end
    end

    // Outputs come straight from registered state
    always_comb begin
        out_valid = (state_q == HOLD);
        busy      = (state_q != IDLE);
        out_data  = out_data_q;
`ifdef PSUM_ACCUM_SATURATE_EN
        sat_flag  = sat_q && (state_q == HOLD);
`endif
    end

endmodule

// File: tb/tb_pointwise_psum_accum.sv
// Testbench for pointwise_psum_accum: two instances (32->32 and 16->20 bit)
// share one stimulus stream; a scoreboard queue holds expected sums and a
// monitor compares them on every output transfer.
module tb_pointwise_psum_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  cfg_num_beats;
    logic        in_valid;
    logic [31:0] in_psum;
    logic        out_ready;

    logic        inReadyA, outValidA, busyA;
    logic [31:0] outDataA;
    logic        inReadyB, outValidB, busyB;
    logic [19:0] outDataB;

    int          checks   = 0;
    int          failures = 0;
    bit          randReady = 1'b0;
    bit          randGaps  = 1'b0;

    logic [31:0] beatQ[$];
    logic [31:0] expAQ[$];
    logic [19:0] expBQ[$];
    string       expNameQ[$];

    pointwise_psum_accum #(.IN_BITWIDTH(32), .OUT_BITWIDTH(32), .CNT_BITWIDTH(8)) u_dutA (
        .clk(clk), .reset(reset), .cfg_num_beats(cfg_num_beats),
        .in_valid(in_valid), .in_ready(inReadyA), .in_psum(in_psum),
        .out_valid(outValidA), .out_ready(out_ready), .out_data(outDataA),
        .busy(busyA)
    );

    pointwise_psum_accum #(.IN_BITWIDTH(16), .OUT_BITWIDTH(20), .CNT_BITWIDTH(8)) u_dutB (
        .clk(clk), .reset(reset), .cfg_num_beats(cfg_num_beats),
        .in_valid(in_valid), .in_ready(inReadyB), .in_psum(in_psum[15:0]),
        .out_valid(outValidB), .out_ready(out_ready), .out_data(outDataB),
        .busy(busyB)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Drives the beats in beatQ as one group; the reference model is a plain
    // signed sum taken modulo each output width, pushed once the group is full.
    task automatic applyStimulus(input string name, input logic [7:0] cfg, input bit scrambleCfg);
        longint      sumA = 0;
        longint      sumB = 0;
        int          need;
        logic [31:0] v;
        logic [15:0] h;
        need = (cfg == 8'd0) ? 1 : int'(cfg);
        cfg_num_beats = cfg;
        for (int i = 0; i < beatQ.size(); i++) begin
            int waited = 0;
            if (randGaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) waitCycle();
            end
            v        = beatQ[i];
            h        = v[15:0];
            in_valid = 1'b1;
            in_psum  = v;
            @(negedge clk);
            while (!inReadyA && waited < 300) begin
                @(negedge clk);
                waited++;
            end
            if (!inReadyA) begin
                checks++;
                failures++;
                $display("[TB] FAIL %s beat_timeout actual=in_ready_low required=accept", name);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            sumA += longint'($signed(v));
            sumB += longint'($signed(h));
            if (i == 0 && scrambleCfg) cfg_num_beats = 8'($urandom);
            if (i + 1 == need) begin
                expAQ.push_back(sumA[31:0]);
                expBQ.push_back(sumB[19:0]);
                expNameQ.push_back(name);
                sumA = 0;
                sumB = 0;
            end
        end
        in_valid = 1'b0;
    endtask

    // Random back-pressure when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (randReady) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compares transfers against the scoreboard and checks hold behaviour
    initial begin
        logic [31:0] heldData;
        bit          holdPending;
        holdPending = 1'b0;
        heldData    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                holdPending = 1'b0;
            end else begin
                checkOutput("validLockstep", 64'(outValidB), 64'(outValidA));
                if (outValidA) begin
                    checkOutput("inReadyInHold", 64'(inReadyA), 64'd0);
                    if (holdPending) checkOutput("holdStable", 64'(outDataA), 64'(heldData));
                end
                if (outValidA && out_ready) begin
                    holdPending = 1'b0;
                    if (expAQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpectedOutput actual=0x%0h required=none", outDataA);
                    end else begin
                        string nm;
                        nm = expNameQ.pop_front();
                        checkOutput({nm, "_A"}, 64'(outDataA), 64'(expAQ.pop_front()));
                        checkOutput({nm, "_B"}, 64'(outDataB), 64'(expBQ.pop_front()));
                    end
                end else if (outValidA) begin
                    holdPending = 1'b1;
                    heldData    = outDataA;
                end else begin
                    holdPending = 1'b0;
                end
            end
        end
    end

    // Directed scenarios followed by randomized groups
    initial begin
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_psum       = '0;
        out_ready     = 1'b1;
        cfg_num_beats = 8'd1;
        #12;
        checkOutput("rstOutValid", 64'(outValidA), 64'd0);
        checkOutput("rstOutData", 64'(outDataA), 64'd0);
        checkOutput("rstBusy", 64'(busyA), 64'd0);
        checkOutput("rstInReady", 64'(inReadyA), 64'd1);
        checkOutput("rstOutDataB", 64'(outDataB), 64'd0);
        reset = 1'b0;
        waitCycle();

        // Basic group: 10 - 3 + 7 + 100
        beatQ = '{32'd10, -32'sd3, 32'd7, 32'd100};
        applyStimulus("basic", 8'd4, 1'b0);
        checkOutput("basicValidNext", 64'(outValidA), 64'd1);
        checkOutput("basicDataNext", 64'(outDataA), 64'd114);
        checkOutput("basicInReadyLow", 64'(inReadyA), 64'd0);
        checkOutput("basicBusy", 64'(busyA), 64'd1);
        waitCycle();
        checkOutput("basicInReadyBack", 64'(inReadyA), 64'd1);
        checkOutput("basicValidDrop", 64'(outValidA), 64'd0);

        // Back-pressure with the next beat waiting
        out_ready = 1'b0;
        beatQ = '{32'd5, 32'd6};
        applyStimulus("bp", 8'd2, 1'b0);
        beatQ = '{32'd9};
        fork
            applyStimulus("bpNext", 8'd1, 1'b0);
            begin
                repeat (5) waitCycle();
                out_ready = 1'b1;
            end
        join
        waitCycle();

        // Degenerate count, sign extension, overflow wrap
        beatQ = '{-32'sd42};
        applyStimulus("zeroCnt", 8'd0, 1'b0);
        waitCycle();
        beatQ = '{32'h0000_8000, 32'h0000_0001};
        applyStimulus("signExt", 8'd2, 1'b0);
        waitCycle();
        beatQ = '{32'h7FFF_FFFF, 32'h0000_0001};
        applyStimulus("overflow", 8'd2, 1'b0);
        waitCycle();

        // Mid-group reset discards the partial sum
        beatQ = '{32'd1000, 32'd2000};
        applyStimulus("partial", 8'd3, 1'b0);
        checkOutput("partialBusy", 64'(busyA), 64'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("midRstValid", 64'(outValidA), 64'd0);
        checkOutput("midRstBusy", 64'(busyA), 64'd0);
        reset = 1'b0;
        beatQ = '{32'd1, 32'd1, 32'd1};
        applyStimulus("afterRst", 8'd3, 1'b0);
        waitCycle();

        // Reset while holding drops the held output
        out_ready = 1'b0;
        beatQ = '{32'd77};
        applyStimulus("holdRst", 8'd1, 1'b0);
        checkOutput("holdRstValidBefore", 64'(outValidA), 64'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("holdRstValid", 64'(outValidA), 64'd0);
        checkOutput("holdRstData", 64'(outDataA), 64'd0);
        void'(expAQ.pop_back());
        void'(expBQ.pop_back());
        void'(expNameQ.pop_back());
        reset     = 1'b0;
        out_ready = 1'b1;
        waitCycle();

        // Maximum count with cfg scrambled mid-group
        beatQ.delete();
        for (int i = 0; i < 255; i++) beatQ.push_back($urandom);
        applyStimulus("maxCnt", 8'd255, 1'b1);
        waitCycle();

        // Randomized groups with gaps and back-pressure
        randReady = 1'b1;
        randGaps  = 1'b1;
        for (int g = 0; g < 40; g++) begin
            int cfg;
            int n;
            cfg = $urandom_range(0, 6);
            n   = (cfg == 0) ? 1 : cfg;
            beatQ.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 0) beatQ.push_back($urandom);
                else beatQ.push_back(32'($signed($urandom_range(0, 200)) - 100));
            end
            applyStimulus("rand", 8'(cfg), 1'b1);
        end
        randReady = 1'b0;
        randGaps  = 1'b0;
        out_ready = 1'b1;
        repeat (5) waitCycle();
        checkOutput("queueDrained", 64'(expAQ.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
